// File: rtl/sram_bus_arbiter_if.sv
// One SRAM-like channel: address phase (req .. wdata / addr_ok) plus data phase (data_ok, rdata).
// The master modport issues requests; the slave modport accepts them and returns data.
interface sram_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between fetch (inst) and load/store (data) masters, routing returns
// in issue order. Define SRAM_ARB_RR_EN for round-robin tie-breaking (default: data over inst).
module sram_bus_arbiter #(
  parameter int unsigned OUTST_DEPTH = 2,
  parameter int unsigned PTR_W       = $clog2(OUTST_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  sram_bus_arbiter_if.slave  inst_bus,
  sram_bus_arbiter_if.slave  data_bus,
  sram_bus_arbiter_if.master mem_bus
);

  localparam logic [PTR_W:0]   FullCount = (PTR_W + 1)'(OUTST_DEPTH);
  localparam logic [PTR_W:0]   CntOne    = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PtrOne    = PTR_W'(1);

  logic [PTR_W:0]         count_q, count_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OUTST_DEPTH-1:0] id_fifo_q, id_fifo_d;
  logic                   lock_valid_q, lock_valid_d;
  logic                   lock_id_q, lock_id_d;

  logic sel;        // 0 = inst, 1 = data
  logic grant;
  logic handshake;
  logic pop;
  logic head;

`ifdef SRAM_ARB_RR_EN
  logic rr_last_q, rr_last_d;
`endif

  // Full check uses registered count only, so mem_data_ok never reaches mem_req.
  always_comb begin
    sel   = 1'b0;
    grant = 1'b0;
    if (lock_valid_q) begin
      sel   = lock_id_q;
      grant = lock_id_q ? data_bus.req : inst_bus.req;
    end else if (count_q == FullCount) begin
      sel   = 1'b0;
      grant = 1'b0;
    end else begin
`ifdef SRAM_ARB_RR_EN
      if (inst_bus.req && data_bus.req) begin
        sel = ~rr_last_q;
      end else begin
        sel = data_bus.req;
      end
`else
      sel = data_bus.req;
`endif
      grant = inst_bus.req | data_bus.req;
    end
  end

  always_comb begin
    mem_bus.req   = grant;
    mem_bus.wr    = sel ? data_bus.wr    : inst_bus.wr;
    mem_bus.size  = sel ? data_bus.size  : inst_bus.size;
    mem_bus.addr  = sel ? data_bus.addr  : inst_bus.addr;
    mem_bus.wstrb = sel ? data_bus.wstrb : inst_bus.wstrb;
    mem_bus.wdata = sel ? data_bus.wdata : inst_bus.wdata;

    handshake = grant && mem_bus.addr_ok;
    head      = id_fifo_q[rd_ptr_q];
    pop       = mem_bus.data_ok && (count_q != '0);

    inst_bus.addr_ok = handshake && !sel;
    data_bus.addr_ok = handshake && sel;
    inst_bus.data_ok = pop && !head;
    data_bus.data_ok = pop && head;
    inst_bus.rdata   = mem_bus.rdata;
    data_bus.rdata   = mem_bus.rdata;
  end

  always_comb begin
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    id_fifo_d    = id_fifo_q;
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;

    if (handshake) begin
      id_fifo_d[wr_ptr_q] = sel;
      wr_ptr_d            = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    unique case ({handshake, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase

    // Hold the winner until its address phase completes.
    if (handshake) begin
      lock_valid_d = 1'b0;
    end else if (grant) begin
      lock_valid_d = 1'b1;
      lock_id_d    = sel;
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    rr_last_d = rr_last_q;
    if (handshake) begin
      rr_last_d = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_q <= 1'b0;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      id_fifo_q    <= '0;
      lock_valid_q <= 1'b0;
      lock_id_q    <= 1'b0;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      id_fifo_q    <= id_fifo_d;
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed, table-driven bench for sram_bus_arbiter (OUTST_DEPTH = 2).
// Each vector drives one cycle of inputs and checks the combinational outputs before the edge.
module tb_sram_bus_arbiter;

  localparam bit N = 1'b0;
  localparam bit Y = 1'b1;
  localparam logic [31:0] Z   = 32'h0;
  localparam logic [31:0] IA  = 32'h1c000000;
  localparam logic [31:0] IA2 = 32'h1c000100;
  localparam logic [31:0] IA3 = 32'h1c000200;
  localparam logic [31:0] DA  = 32'h1c008000;

  typedef struct {
    bit          rst;
    bit          ireq;
    logic [31:0] iaddr;
    bit          dreq;
    logic [31:0] daddr;
    bit          dwr;
    bit          mao;
    bit          mdo;
    logic [31:0] mrd;
    bit          chk;
    bit          emreq;
    bit          esel;
    bit          eiao;
    bit          edao;
    bit          eido;
    bit          eddo;
    bit          ezero;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  sram_bus_arbiter_if inst_bus ();
  sram_bus_arbiter_if data_bus ();
  sram_bus_arbiter_if mem_bus ();

  sram_bus_arbiter #(
    .OUTST_DEPTH(2),
    .PTR_W      (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .inst_bus(inst_bus),
    .data_bus(data_bus),
    .mem_bus (mem_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    reset             = v.rst;
    inst_bus.req      = v.ireq;
    inst_bus.wr       = 1'b0;
    inst_bus.size     = v.ireq ? 2'd2 : 2'd0;
    inst_bus.addr     = v.iaddr;
    inst_bus.wstrb    = v.ireq ? 4'hf : 4'h0;
    inst_bus.wdata    = v.ireq ? 32'h11111111 : 32'h0;
    data_bus.req      = v.dreq;
    data_bus.wr       = v.dwr;
    data_bus.size     = v.dreq ? 2'd1 : 2'd0;
    data_bus.addr     = v.daddr;
    data_bus.wstrb    = v.dreq ? 4'h3 : 4'h0;
    data_bus.wdata    = v.dreq ? 32'hdeadbeef : 32'h0;
    mem_bus.addr_ok   = v.mao;
    mem_bus.data_ok   = v.mdo;
    mem_bus.rdata     = v.mrd;
    #2;
    if (v.chk) begin
      chk({tag, ".mem_req"}, {31'b0, mem_bus.req}, {31'b0, v.emreq});
      chk({tag, ".inst_addr_ok"}, {31'b0, inst_bus.addr_ok}, {31'b0, v.eiao});
      chk({tag, ".data_addr_ok"}, {31'b0, data_bus.addr_ok}, {31'b0, v.edao});
      chk({tag, ".inst_data_ok"}, {31'b0, inst_bus.data_ok}, {31'b0, v.eido});
      chk({tag, ".data_data_ok"}, {31'b0, data_bus.data_ok}, {31'b0, v.eddo});
      chk({tag, ".inst_rdata"}, inst_bus.rdata, v.mrd);
      chk({tag, ".data_rdata"}, data_bus.rdata, v.mrd);
      if (v.emreq) begin
        chk({tag, ".mem_addr"}, mem_bus.addr, v.esel ? v.daddr : v.iaddr);
        chk({tag, ".mem_wr"}, {31'b0, mem_bus.wr}, {31'b0, v.esel ? v.dwr : 1'b0});
        chk({tag, ".mem_size"}, {30'b0, mem_bus.size}, v.esel ? 32'd1 : 32'd2);
        chk({tag, ".mem_wstrb"}, {28'b0, mem_bus.wstrb}, v.esel ? 32'h3 : 32'hf);
        chk({tag, ".mem_wdata"}, mem_bus.wdata, v.esel ? 32'hdeadbeef : 32'h11111111);
      end
      if (v.ezero) begin
        chk({tag, ".zero_addr"}, mem_bus.addr, Z);
        chk({tag, ".zero_ctl"}, {25'b0, mem_bus.wr, mem_bus.size, mem_bus.wstrb}, Z);
        chk({tag, ".zero_wdata"}, mem_bus.wdata, Z);
      end
    end
  endtask

  vec_t tbl[11];

  initial begin
    tbl = '{
      // rst ireq iaddr dreq daddr dwr mao mdo mrd  chk mreq sel iao dao ido ddo zero
      '{N, N, Z,   N, Z,  N, N, N, Z,            Y, N, N, N, N, N, N, Y},
      '{N, Y, IA,  N, Z,  N, Y, N, Z,            Y, Y, N, Y, N, N, N, N},
      '{N, N, Z,   N, Z,  N, N, Y, 32'h02800c0c, Y, N, N, N, N, Y, N, N},
      '{N, N, Z,   N, Z,  N, N, Y, 32'h12345678, Y, N, N, N, N, N, N, N},
      '{N, Y, IA2, Y, DA, Y, Y, N, Z,            Y, Y, Y, N, Y, N, N, N},
      '{N, Y, IA2, N, Z,  N, Y, N, Z,            Y, Y, N, Y, N, N, N, N},
      '{N, N, Z,   N, Z,  N, N, Y, 32'haaaa0001, Y, N, N, N, N, N, Y, N},
      '{N, N, Z,   N, Z,  N, N, Y, 32'hbbbb0002, Y, N, N, N, N, Y, N, N},
      '{N, N, Z,   N, Z,  N, N, Y, 32'hcccc0003, Y, N, N, N, N, N, N, N},
      '{N, Y, IA3, N, Z,  N, Y, N, Z,            Y, Y, N, Y, N, N, N, N},
      '{N, N, Z,   N, Z,  N, N, Y, 32'h0000dddd, Y, N, N, N, N, Y, N, N}
    };

    reset           = 1'b1;
    inst_bus.req    = 1'b0;
    data_bus.req    = 1'b0;
    mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = 1'b0;
    mem_bus.rdata   = 32'h0;
    repeat (2) @(posedge clk);

    // Single fetch, conflict, spurious returns.
    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Lock: inst stalled three cycles, data arrives mid-handshake and must wait.
    run_vec('{N, Y, IA, N, Z,  N, N, N, Z, Y, Y, N, N, N, N, N, N}, "lock1");
    run_vec('{N, Y, IA, Y, DA, N, N, N, Z, Y, Y, N, N, N, N, N, N}, "lock2");
    run_vec('{N, Y, IA, Y, DA, N, N, N, Z, Y, Y, N, N, N, N, N, N}, "lock3");
    run_vec('{N, Y, IA, Y, DA, N, Y, N, Z, Y, Y, N, Y, N, N, N, N}, "lock4");
    run_vec('{N, N, Z,  Y, DA, N, Y, N, Z, Y, Y, Y, N, Y, N, N, N}, "lock5");
    run_vec('{N, N, Z,  N, Z,  N, N, Y, 32'h01010101, Y, N, N, N, N, Y, N, N}, "lock_ret1");
    run_vec('{N, N, Z,  N, Z,  N, N, Y, 32'h02020202, Y, N, N, N, N, N, Y, N}, "lock_ret2");

    // Full: third request blocked despite a same-cycle return; pointers wrap over 5 transactions.
    run_vec('{N, Y, IA,  N, Z,  N, Y, N, Z, Y, Y, N, Y, N, N, N, N}, "full1");
    run_vec('{N, Y, IA2, N, Z,  N, Y, N, Z, Y, Y, N, Y, N, N, N, N}, "full2");
    run_vec('{N, N, Z,   Y, DA, N, Y, Y, 32'h0f0f0f0f, Y, N, N, N, N, Y, N, N}, "full3");
    run_vec('{N, N, Z,   Y, DA, N, Y, N, Z, Y, Y, Y, N, Y, N, N, N}, "full4");
    run_vec('{N, N, Z,   N, Z,  N, N, Y, 32'h10000001, Y, N, N, N, N, Y, N, N}, "full5");
    run_vec('{N, Y, IA3, N, Z,  N, Y, Y, 32'h10000002, Y, Y, N, Y, N, N, Y, N}, "full6");
    run_vec('{N, N, Z,   Y, DA, Y, Y, N, Z, Y, Y, Y, N, Y, N, N, N}, "full7");
    run_vec('{N, N, Z,   N, Z,  N, N, Y, 32'h10000003, Y, N, N, N, N, Y, N, N}, "full8");
    run_vec('{N, N, Z,   N, Z,  N, N, Y, 32'h10000004, Y, N, N, N, N, N, Y, N}, "full9");
    run_vec('{N, N, Z,   N, Z,  N, N, Y, 32'h10000005, Y, N, N, N, N, N, N, N}, "full10");

    // Reset with one outstanding transaction and data locked mid-handshake.
    run_vec('{N, Y, IA, N, Z,  N, Y, N, Z, Y, Y, N, Y, N, N, N, N}, "rst1");
    run_vec('{N, N, Z,  Y, DA, N, N, N, Z, Y, Y, Y, N, N, N, N, N}, "rst2");
    run_vec('{Y, N, Z,  N, Z,  N, N, N, Z, N, N, N, N, N, N, N, N}, "rst3");
    run_vec('{N, N, Z,  N, Z,  N, N, N, Z, Y, N, N, N, N, N, N, Y}, "rst4");
    run_vec('{N, N, Z,  N, Z,  N, N, Y, 32'h55aa55aa, Y, N, N, N, N, N, N, N}, "rst5");
    run_vec('{N, Y, IA, N, Z,  N, N, N, Z, Y, Y, N, N, N, N, N, N}, "rst6");
    run_vec('{N, Y, IA, N, Z,  N, Y, N, Z, Y, Y, N, Y, N, N, N, N}, "rst7");
    run_vec('{N, N, Z,  N, Z,  N, N, Y, 32'h66666666, Y, N, N, N, N, Y, N, N}, "rst8");

`ifdef SRAM_ARB_RR_EN
    // Alternating ties after inst was last granted: data, inst, data.
    run_vec('{N, Y, IA, Y, DA, N, Y, N, Z, Y, Y, Y, N, Y, N, N, N}, "rr1");
    run_vec('{N, Y, IA, Y, DA, N, Y, N, Z, Y, Y, N, Y, N, N, N, N}, "rr2");
    run_vec('{N, N, Z,  N, Z,  N, N, Y, 32'h77770001, Y, N, N, N, N, N, Y, N}, "rr_ret1");
    run_vec('{N, N, Z,  N, Z,  N, N, Y, 32'h77770002, Y, N, N, N, N, Y, N, N}, "rr_ret2");
    run_vec('{N, Y, IA, Y, DA, N, Y, N, Z, Y, Y, Y, N, Y, N, N, N}, "rr3");
    run_vec('{N, N, Z,  N, Z,  N, N, Y, 32'h77770003, Y, N, N, N, N, N, Y, N}, "rr_ret3");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like memory port between the fetch requester (inst) and the load/store requester (data).
- Sits between the IF and EX/MEM stages and the single memory bridge.
- Grants address-phase requests and holds the grant until the address handshake completes.
- Tracks in-order outstanding transactions and routes each data_ok/rdata return to the master that issued the request.

Parameters:
- OUTST_DEPTH, 2: maximum accepted-but-unreturned transactions. Power of two, range 2..8.
- PTR_W, 1: log2(OUTST_DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous reset, active-high
- inst_req  in  1  fetch master request
- inst_wr  in  1  fetch write flag (normally 0)
- inst_size  in  2  access size code
- inst_addr  in  32  fetch address
- inst_wstrb  in  4  byte strobes
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  fetch address handshake
- inst_data_ok  out  1  fetch data return
- inst_rdata  out  32  fetch read data
- data_req / data_wr / data_size / data_addr / data_wstrb / data_wdata  in  1/1/2/32/4/32  load/store master fields, same meaning as the inst_* fields
- data_addr_ok  out  1  load/store address handshake
- data_data_ok  out  1  load/store data return
- data_rdata  out  32  load/store read data
- mem_req / mem_wr / mem_size / mem_addr / mem_wstrb / mem_wdata  out  1/1/2/32/4/32  shared port request fields
- mem_addr_ok  in  1  slave address accept
- mem_data_ok  in  1  slave data return, in issue order
- mem_rdata  in  32  slave read data

Behaviour:
- Address handshake: a transaction is accepted in any cycle where mem_req && mem_addr_ok.
- Masters hold req and all fields stable from assertion until their addr_ok.
- Grant selection (combinational; winner = sel):
  - If lock_valid: sel = lock_id.
  - Else if count == OUTST_DEPTH: no grant, mem_req = 0.
  - Else the priority rule below picks among the asserted reqs.
- mem_* fields are muxed from sel. mem_req = the selected master's req.
- {inst,data}_addr_ok = mem_addr_ok && mem_req && (sel == that master). The losing master sees addr_ok = 0.
- Lock register:
  - Set (lock_valid = 1, lock_id = sel) when mem_req && !mem_addr_ok.
  - Cleared on the cycle mem_addr_ok completes the handshake.
  - Priority never switches mid-handshake.
- Default priority: data over inst (fixed).
- ID FIFO: OUTST_DEPTH entries of 1 bit (0 = inst, 1 = data), with wr_ptr, rd_ptr and count (PTR_W+1 bits).
  - Push sel on an address handshake.
  - Pop on mem_data_ok when count != 0.
  - Pointers wrap modulo OUTST_DEPTH.
  - Simultaneous push and pop leaves count unchanged; both pointers advance.
- Full: the grant is blocked when count == OUTST_DEPTH, even if mem_data_ok pops in the same cycle. There is no combinational path from mem_data_ok to mem_req.
- Return routing:
  - inst_data_ok = mem_data_ok && count != 0 && head == 0.
  - data_data_ok = mem_data_ok && count != 0 && head == 1.
  - inst_rdata = data_rdata = mem_rdata, unconditionally.
- mem_data_ok with count == 0 is a protocol violation: both data_ok outputs stay 0, no pop, count stays 0.
- Reset (synchronous, active-high):
  - count = 0, wr_ptr = rd_ptr = 0, lock_valid = 0, lock_id = 0, rr_last = 0.
  - Reset overrides any pending handshake; a transaction in flight is dropped.
  - After reset, with all inputs 0, every output is 0.
- Latency: zero-cycle combinational pass-through on both the address phase and the data phase. Only the lock, FIFO and rr state are registered.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: round-robin priority on simultaneous unlocked requests. rr_last records the last granted master (updated on each address handshake). The other master wins the next tie. rr_last resets to 0 (inst), so data wins the first tie.
- Undefined: fixed data-over-inst priority, and the rr_last register is not present.
- Lock and FIFO behaviour are identical in both builds.

Test Plan:
- Single fetch: inst_req = 1, addr 0x1c000000, mem_addr_ok = 1 in the same cycle. Expect inst_addr_ok = 1 that cycle. One cycle later, mem_data_ok = 1 with rdata 0x02800c0c gives inst_data_ok = 1, inst_rdata = 0x02800c0c, data_data_ok = 0.
- Conflict (macro undefined): inst_req and data_req both held, data_addr 0x1c008000. Expect mem_addr = 0x1c008000 and data_addr_ok first. Inst is granted the following cycle. Returns arrive in order, data first.
- Lock: inst alone requests with mem_addr_ok = 0 for 3 cycles; data_req rises in cycle 2. mem_addr must stay the inst address until mem_addr_ok, then data is granted.
- Full: OUTST_DEPTH = 2, two handshakes, no returns. A third request gives mem_req = 0 even with mem_data_ok = 1 that cycle. Next cycle the request is granted, and the count wrap is verified over 5 transactions.
- Spurious return: count = 0 and mem_data_ok = 1. Expect both data_ok = 0 and count still 0.
- Reset mid-flight: assert reset with count = 1 and lock_valid = 1. The next cycle shows count = 0, a cleared lock, and all outputs 0 with idle inputs. With SRAM_ARB_RR_EN, alternating ties grant data, inst, data.
